// File: rtl/bit7_1_2_stream_demux_pkg.sv
// Shared definitions for the 7-bit 1:2 stream demux: word width, default sizing
// and the select encoding shared with the 2:1 mux.
package bit7_1_2_stream_demux_pkg;

  localparam int unsigned WORD_W    = 7;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DEF_CNT_W = 8;

  localparam logic SEL_OUT1 = 1'b1;
  localparam logic SEL_OUT2 = 1'b0;

  typedef enum logic {
    ROUTE_OUT2 = SEL_OUT2,
    ROUTE_OUT1 = SEL_OUT1
  } route_e;

  // Ready towards the producer comes only from registered fullness, never from out*_ready.
  function automatic logic route_ready(input route_e route, input logic full1, input logic full2);
    return (route == ROUTE_OUT1) ? !full1 : !full2;
  endfunction

endpackage

// File: rtl/bit7_1_2_stream_demux_if.sv
// Handshake bundle of the demux: one producer-side stream and two consumer-side streams.
interface bit7_1_2_stream_demux_if #(
  parameter int unsigned WIDTH = 7
);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  logic [WIDTH-1:0] out2_data;
  logic             out2_valid;
  logic             out2_ready;

  // Environment side: producer plus both consumers.
  modport master (
    output in_data, in_sel, in_valid, out1_ready, out2_ready,
    input  in_ready, out1_data, out1_valid, out2_data, out2_valid
  );

  // Demux side.
  modport slave (
    input  in_data, in_sel, in_valid, out1_ready, out2_ready,
    output in_ready, out1_data, out1_valid, out2_data, out2_valid
  );

endinterface

// File: rtl/bit7_1_2_stream_demux_sync_fifo.sv
// Small synchronous FIFO with level output; head reads as zero while empty.
module bit7_sync_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bit7_1_2_stream_demux.sv
// 1:2 stream demux: steers each input word by in_sel into one of two per-output FIFOs
// and counts the words accepted for each destination.
module bit7_1_2_stream_demux
  import bit7_1_2_stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bit7_1_2_stream_demux_if.slave bus,
  output logic [$clog2(DEPTH):0] out1_level,
  output logic [$clog2(DEPTH):0] out2_level,
  output logic [CNT_W-1:0]       out1_cnt,
  output logic [CNT_W-1:0]       out2_cnt
);

  route_e     route;
  logic       full1;
  logic       full2;
  logic       empty1;
  logic       empty2;
  logic       accept;
  logic       push1;
  logic       push2;
  logic       pop1;
  logic       pop2;

  assign route        = route_e'(bus.in_sel);
  assign bus.in_ready = route_ready(route, full1, full2);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push1        = accept && (route == ROUTE_OUT1);
  assign push2        = accept && (route == ROUTE_OUT2);

  assign bus.out1_valid = !empty1;
  assign bus.out2_valid = !empty2;
  assign pop1           = bus.out1_valid && bus.out1_ready;
  assign pop2           = bus.out2_valid && bus.out2_ready;

  bit7_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (bus.in_data),
    .pop       (pop1),
    .head      (bus.out1_data),
    .level     (out1_level),
    .full      (full1),
    .empty     (empty1)
  );

  bit7_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push2),
    .push_data (bus.in_data),
    .pop       (pop2),
    .head      (bus.out2_data),
    .level     (out2_level),
    .full      (full2),
    .empty     (empty2)
  );

  // Counters wrap freely; they track accepted words, not delivered ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_cnt <= '0;
      out2_cnt <= '0;
    end else begin
      if (push1) out1_cnt <= out1_cnt + 1'b1;
      if (push2) out2_cnt <= out2_cnt + 1'b1;
    end
  end

endmodule
